byte_order_stream: RTL

// - Streaming, registered byte-order converter. Accepts a BYTE_COUNT x BYTE_SIZE word per beat over

---
 rtl/byte_order_pkg.sv | 24 ++
 rtl/byte_lane_permute.sv | 49 ++++
 rtl/byte_order_stream.sv | 113 +++++++++++
 3 files changed

// File: rtl/byte_order_pkg.sv
// Shared definitions for the byte-order stream converter: permutation mode
// encodings and the lane-source mapping used to build the byte crossbar.
package byte_order_pkg;

    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_REVERSE = 2'b01;
    localparam logic [1:0] MODE_SWAP16  = 2'b10;
    localparam logic [1:0] MODE_HWREV   = 2'b11;

    // Input lane feeding output lane j for a word of n lanes. Evaluated at
    // elaboration time only, so every output lane becomes a fixed 4:1 mux.
    function automatic int lane_src(input logic [1:0] mode, input int j, input int n);
        int src;
        src = j;
        case (mode)
            MODE_REVERSE: src = n - 1 - j;
            MODE_SWAP16:  src = j ^ 1;
            MODE_HWREV:   src = (n - 2 - (j & ~1)) | (j & 1);
            default:      src = j;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/byte_lane_permute.sv
// Combinational byte crossbar: routes data lanes and their keep bits together
// according to the selected permutation mode.
module byte_lane_permute
    import byte_order_pkg::*;
#(
    parameter int BYTE_COUNT = 4,
    parameter int BYTE_SIZE  = 8
) (
    input  logic [1:0]                      mode,
    input  logic [BYTE_COUNT*BYTE_SIZE-1:0] in_data,
    input  logic [BYTE_COUNT-1:0]           in_keep,
    output logic [BYTE_COUNT*BYTE_SIZE-1:0] out_data,
    output logic [BYTE_COUNT-1:0]           out_keep
);

    for (genvar j = 0; j < BYTE_COUNT; j++) begin : g_lane
        localparam int SRC_PASS    = lane_src(MODE_PASS,    j, BYTE_COUNT);
        localparam int SRC_REVERSE = lane_src(MODE_REVERSE, j, BYTE_COUNT);
        localparam int SRC_SWAP16  = lane_src(MODE_SWAP16,  j, BYTE_COUNT);
        localparam int SRC_HWREV   = lane_src(MODE_HWREV,   j, BYTE_COUNT);

        logic [BYTE_SIZE-1:0] lane_data;
        logic                 lane_keep;

        always_comb begin
            lane_data = in_data[BYTE_SIZE*SRC_PASS +: BYTE_SIZE];
            lane_keep = in_keep[SRC_PASS];
            case (mode)
                MODE_REVERSE: begin
                    lane_data = in_data[BYTE_SIZE*SRC_REVERSE +: BYTE_SIZE];
                    lane_keep = in_keep[SRC_REVERSE];
                end
                MODE_SWAP16: begin
                    lane_data = in_data[BYTE_SIZE*SRC_SWAP16 +: BYTE_SIZE];
                    lane_keep = in_keep[SRC_SWAP16];
                end
                MODE_HWREV: begin
                    lane_data = in_data[BYTE_SIZE*SRC_HWREV +: BYTE_SIZE];
                    lane_keep = in_keep[SRC_HWREV];
                end
                default: ;
            endcase
        end

        assign out_data[BYTE_SIZE*j +: BYTE_SIZE] = lane_data;
        assign out_keep[j]                        = lane_keep;
    end

endmodule

// File: rtl/byte_order_stream.sv
// Registered streaming byte-order converter: permutes each beat on entry and
// holds it in an output register backed by one skid entry for a registered in_ready.
module byte_order_stream
    import byte_order_pkg::*;
#(
    parameter int BYTE_COUNT = 4,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      mode,
    input  logic [BYTE_COUNT*BYTE_SIZE-1:0] in_data,
    input  logic [BYTE_COUNT-1:0]           in_keep,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [BYTE_COUNT*BYTE_SIZE-1:0] out_data,
    output logic [BYTE_COUNT-1:0]           out_keep,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int DATA_W = BYTE_COUNT * BYTE_SIZE;

    if (BYTE_COUNT < 2 || (BYTE_COUNT & (BYTE_COUNT - 1)) != 0 || BYTE_SIZE < 1) begin : g_bad_param
        $error("byte_order_stream: BYTE_COUNT must be a power of two >= 2 and BYTE_SIZE >= 1");
    end

    logic [DATA_W-1:0]     perm_data;
    logic [BYTE_COUNT-1:0] perm_keep;

    // Mode is applied on entry, so a stored beat never depends on later mode values.
    byte_lane_permute #(
        .BYTE_COUNT (BYTE_COUNT),
        .BYTE_SIZE  (BYTE_SIZE)
    ) u_permute (
        .mode     (mode),
        .in_data  (in_data),
        .in_keep  (in_keep),
        .out_data (perm_data),
        .out_keep (perm_keep)
    );

    logic [DATA_W-1:0]     out_data_q,  out_data_d;
    logic [BYTE_COUNT-1:0] out_keep_q,  out_keep_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     skid_data_q, skid_data_d;
    logic [BYTE_COUNT-1:0] skid_keep_q, skid_keep_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  in_fire;

    always_comb begin
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_valid_d = skid_valid_q;
        in_fire      = in_valid && in_ready_q;

        if (skid_valid_q) begin
            // in_ready is low whenever the skid is occupied, so no new beat can arrive here.
            if (out_ready) begin
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = perm_data;
                out_keep_d  = perm_keep;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = perm_data;
                skid_keep_d  = perm_keep;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Skid payload is only meaningful while skid_valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_keep_q <= skid_keep_d;
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;

endmodule
